// File: rtl/mdl_z14seq_if.sv
// Z14 acquisition sequencer bus.
// Page controller / evaluator side is master, sequencer is slave.
interface mdl_z14seq_if;
   logic       i_CLK2M_PCEN_n;
   logic       i_BITSTB;
   logic       i_ACQ_REQ;
   logic       i_ABORT;
   logic [9:0] i_PAGE_LEN;
   logic       i_Z14_LOCKED_n;
   logic       i_Z14_n;
   logic       o_ACQ_START;
   logic       o_Z14_ERR_n;
   logic       o_TIMER25K_TIMEOVER_n;
   logic       o_DLCNT_START_n;
   logic       o_SUPBD_ACT_n;
   logic       o_SUPBDLCNTR_CNT;
   logic       o_SUPBD_END_n;
   logic [9:0] o_BITCNT;
   logic       o_BUSY;
   logic       o_DONE;
   logic       o_CRC_OK;
   logic       o_TIMEOUT;

   modport master (
      output i_CLK2M_PCEN_n, i_BITSTB, i_ACQ_REQ, i_ABORT,
      output i_PAGE_LEN, i_Z14_LOCKED_n, i_Z14_n,
      input  o_ACQ_START, o_Z14_ERR_n, o_TIMER25K_TIMEOVER_n,
      input  o_DLCNT_START_n, o_SUPBD_ACT_n, o_SUPBDLCNTR_CNT,
      input  o_SUPBD_END_n, o_BITCNT, o_BUSY, o_DONE,
      input  o_CRC_OK, o_TIMEOUT
   );

   modport slave (
      input  i_CLK2M_PCEN_n, i_BITSTB, i_ACQ_REQ, i_ABORT,
      input  i_PAGE_LEN, i_Z14_LOCKED_n, i_Z14_n,
      output o_ACQ_START, o_Z14_ERR_n, o_TIMER25K_TIMEOVER_n,
      output o_DLCNT_START_n, o_SUPBD_ACT_n, o_SUPBDLCNTR_CNT,
      output o_SUPBD_END_n, o_BITCNT, o_BUSY, o_DONE,
      output o_CRC_OK, o_TIMEOUT
   );
endinterface

// File: rtl/mdl_z14seq.sv
// Z14 (CRC14) acquisition sequencer: strobes, lock-hunt timer,
// bit counting and CRC pass/fail capture per block.
module mdl_z14seq #(
   parameter int unsigned TIMEOUT_CYC = 25000
) (
   input logic         i_MCLK,
   input logic         i_SYS_RST_n,
   mdl_z14seq_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_HUNT, S_START, S_DATA, S_END, S_CHECK
   } state_t;

   localparam logic [14:0] TLAST = 15'(TIMEOUT_CYC - 1);

   state_t      state;
   logic [14:0] timer;
   logic [9:0]  len;
   logic [9:0]  bitcnt;
   logic        acq_start;
   logic        z14_err_n;
   logic        tover_n;
   logic        dl_start_n;
   logic        act_n;
   logic        end_n;
   logic        busy;
   logic        done;
   logic        crc_ok;
   logic        timeout;
   logic [9:0]  len_m1;
   logic        cen;

   assign cen    = ~bus.i_CLK2M_PCEN_n;
   assign len_m1 = len - 10'd1;

   // Strobes are registered on entry so each lasts exactly its state.
   always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
      if (!i_SYS_RST_n) begin
         state      <= S_IDLE;
         timer      <= '0;
         len        <= '0;
         bitcnt     <= '0;
         acq_start  <= 1'b0;
         z14_err_n  <= 1'b1;
         tover_n    <= 1'b1;
         dl_start_n <= 1'b1;
         act_n      <= 1'b1;
         end_n      <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         crc_ok     <= 1'b0;
         timeout    <= 1'b0;
      end else if (cen) begin
         acq_start  <= 1'b0;
         z14_err_n  <= 1'b1;
         tover_n    <= 1'b1;
         dl_start_n <= 1'b1;
         end_n      <= 1'b1;
         done       <= 1'b0;
         if (state != S_IDLE && bus.i_ABORT) begin
            state     <= S_IDLE;
            z14_err_n <= 1'b0;
            done      <= 1'b1;
            act_n     <= 1'b1;
            busy      <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (bus.i_ACQ_REQ) begin
                     len       <= bus.i_PAGE_LEN;
                     crc_ok    <= 1'b0;
                     timeout   <= 1'b0;
                     timer     <= '0;
                     bitcnt    <= '0;
                     state     <= S_ARM;
                     acq_start <= 1'b1;
                     z14_err_n <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
               S_ARM: state <= S_HUNT;
               S_HUNT: begin
                  timer <= timer + 15'd1;
                  if (!bus.i_Z14_LOCKED_n) begin
                     state      <= S_START;
                     dl_start_n <= 1'b0;
                  end else if (timer == TLAST) begin
                     state     <= S_IDLE;
                     tover_n   <= 1'b0;
                     z14_err_n <= 1'b0;
                     timeout   <= 1'b1;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end
               end
               S_START: begin
                  state <= S_DATA;
                  act_n <= 1'b0;
               end
               S_DATA: begin
                  if (bus.i_BITSTB) begin
                     bitcnt <= bitcnt + 10'd1;
                     if (bitcnt == len_m1) begin
                        state <= S_END;
                        end_n <= 1'b0;
                        act_n <= 1'b1;
                     end
                  end
               end
               S_END: state <= S_CHECK;
               S_CHECK: begin
                  crc_ok <= ~bus.i_Z14_n;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_ACQ_START           = acq_start;
   assign bus.o_Z14_ERR_n           = z14_err_n;
   assign bus.o_TIMER25K_TIMEOVER_n = tover_n;
   assign bus.o_DLCNT_START_n       = dl_start_n;
   assign bus.o_SUPBD_ACT_n         = act_n;
   assign bus.o_SUPBDLCNTR_CNT      = bus.i_BITSTB & (state == S_DATA);
   assign bus.o_SUPBD_END_n         = end_n;
   assign bus.o_BITCNT              = bitcnt;
   assign bus.o_BUSY                = busy;
   assign bus.o_DONE                = done;
   assign bus.o_CRC_OK              = crc_ok;
   assign bus.o_TIMEOUT             = timeout;

endmodule

// File: tb/tb_mdl_z14seq.sv
// Bench for mdl_z14seq: random blocks scored against cycle
// expectations derived from block length, lock delay and CRC flag.
module tb_mdl_z14seq;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;
   logic m_crc = 1'b0;
   logic m_to = 1'b0;

   always #5 clk = ~clk;

   mdl_z14seq_if bus();

   mdl_z14seq #(.TIMEOUT_CYC(TO)) dut (
      .i_MCLK(clk),
      .i_SYS_RST_n(rst_n),
      .bus(bus)
   );

   function automatic logic [9:0] ov();
      return {bus.o_ACQ_START, bus.o_Z14_ERR_n,
              bus.o_TIMER25K_TIMEOVER_n, bus.o_DLCNT_START_n,
              bus.o_SUPBD_ACT_n, bus.o_SUPBD_END_n, bus.o_BUSY,
              bus.o_DONE, bus.o_CRC_OK, bus.o_TIMEOUT};
   endfunction

   // Expected outputs from active-high event flags plus sticky model.
   function automatic logic [9:0] ev(
      bit acq, bit err, bit tov, bit dls,
      bit act, bit endp, bit bsy, bit dn);
      return {acq, ~err, ~tov, ~dls, ~act, ~endp, bsy, dn,
              m_crc, m_to};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.i_ACQ_REQ = 1'b1;
      tick();
      tick();
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,0))
         $display("FAIL reset_outs got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,0,0));
      else passed++;
      total++;
      if (bus.o_BITCNT !== 10'd0)
         $display("FAIL reset_bitcnt got=%0d want=0", bus.o_BITCNT);
      else passed++;
      bus.i_ACQ_REQ = 1'b0;
      #2 rst_n = 1'b1;
      tick();
   endtask

   // Runs one complete block; leaves the bench in the o_DONE cycle.
   task automatic run_block(input int len_in, input int k,
                            input bit z, input bit stb_start,
                            input int dens);
      int n;
      int cnt;
      int guard;
      n = (len_in == 0) ? 1024 : len_in;
      bus.i_PAGE_LEN = 10'(len_in);
      bus.i_ACQ_REQ = 1'b1;
      tick();
      bus.i_ACQ_REQ = 1'b0;
      m_crc = 1'b0;
      m_to = 1'b0;
      total++;
      if (ov() !== ev(1,1,0,0,0,0,1,0))
         $display("FAIL arm got=%b want=%b",
                  ov(), ev(1,1,0,0,0,0,1,0));
      else passed++;
      tick();
      total++;
      if (ov() !== ev(0,0,0,0,0,0,1,0))
         $display("FAIL hunt_entry got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,1,0));
      else passed++;
      for (int h = 1; h <= k; h++) begin
         bus.i_Z14_LOCKED_n = (h == k) ? 1'b0 : 1'b1;
         tick();
         if (h < k) begin
            total++;
            if (ov() !== ev(0,0,0,0,0,0,1,0))
               $display("FAIL hunt h=%0d got=%b want=%b",
                        h, ov(), ev(0,0,0,0,0,0,1,0));
            else passed++;
         end
      end
      bus.i_Z14_LOCKED_n = 1'b1;
      total++;
      if (ov() !== ev(0,0,0,1,0,0,1,0))
         $display("FAIL start k=%0d got=%b want=%b",
                  k, ov(), ev(0,0,0,1,0,0,1,0));
      else passed++;
      bus.i_BITSTB = stb_start;
      #1;
      total++;
      if (bus.o_SUPBDLCNTR_CNT !== 1'b0)
         $display("FAIL start_cnt got=%b want=0",
                  bus.o_SUPBDLCNTR_CNT);
      else passed++;
      tick();
      bus.i_BITSTB = 1'b0;
      total++;
      if (ov() !== ev(0,0,0,0,1,0,1,0) || bus.o_BITCNT !== 10'd0)
         $display("FAIL data_entry got=%b/%0d want=%b/0",
                  ov(), bus.o_BITCNT, ev(0,0,0,0,1,0,1,0));
      else passed++;
      cnt = 0;
      guard = 0;
      while (cnt < n && guard < 4 * n + 16) begin
         bus.i_BITSTB = ($urandom_range(99) < dens);
         #1;
         total++;
         if (bus.o_SUPBDLCNTR_CNT !== bus.i_BITSTB)
            $display("FAIL data_cnt got=%b want=%b",
                     bus.o_SUPBDLCNTR_CNT, bus.i_BITSTB);
         else passed++;
         tick();
         if (bus.i_BITSTB) cnt++;
         bus.i_BITSTB = 1'b0;
         guard++;
         if (cnt < n) begin
            total++;
            if (ov() !== ev(0,0,0,0,1,0,1,0) ||
                bus.o_BITCNT !== 10'(cnt))
               $display("FAIL data got=%b/%0d want=%b/%0d",
                        ov(), bus.o_BITCNT,
                        ev(0,0,0,0,1,0,1,0), cnt);
            else passed++;
         end
      end
      total++;
      if (cnt != n)
         $display("FAIL strobe_budget got=%0d want=%0d", cnt, n);
      else passed++;
      total++;
      if (ov() !== ev(0,0,0,0,0,1,1,0) || bus.o_BITCNT !== 10'(n))
         $display("FAIL end got=%b/%0d want=%b/%0d",
                  ov(), bus.o_BITCNT, ev(0,0,0,0,0,1,1,0), n % 1024);
      else passed++;
      bus.i_Z14_n = z;
      tick();
      total++;
      if (ov() !== ev(0,0,0,0,0,0,1,0))
         $display("FAIL check got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,1,0));
      else passed++;
      tick();
      bus.i_Z14_n = 1'b1;
      m_crc = ~z;
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,1))
         $display("FAIL done z=%0d got=%b want=%b",
                  z, ov(), ev(0,0,0,0,0,0,0,1));
      else passed++;
   endtask

   task automatic test_crc_pass();
      run_block(16, 3, 1'b0, 1'b1, 100);
   endtask

   task automatic test_back_to_back();
      run_block(16, 3, 1'b1, 1'b0, 60);
      run_block(5, 1, 1'b0, 1'b1, 50);
   endtask

   task automatic test_timeout();
      bus.i_ACQ_REQ = 1'b1;
      tick();
      bus.i_ACQ_REQ = 1'b0;
      m_crc = 1'b0;
      m_to = 1'b0;
      tick();
      for (int h = 1; h <= TO; h++) begin
         tick();
         if (h < TO) begin
            total++;
            if (ov() !== ev(0,0,0,0,0,0,1,0))
               $display("FAIL to_hunt h=%0d got=%b want=%b",
                        h, ov(), ev(0,0,0,0,0,0,1,0));
            else passed++;
         end
      end
      m_to = 1'b1;
      total++;
      if (ov() !== ev(0,1,1,0,0,0,0,1))
         $display("FAIL timeover got=%b want=%b",
                  ov(), ev(0,1,1,0,0,0,0,1));
      else passed++;
      tick();
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,0))
         $display("FAIL to_sticky got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,0,0));
      else passed++;
   endtask

   task automatic test_lock_timeout_tie();
      run_block(12, TO, 1'b0, 1'b0, 70);
   endtask

   task automatic test_wrap();
      run_block(0, 1, 1'b0, 1'b0, 100);
      total++;
      if (bus.o_BITCNT !== 10'd0)
         $display("FAIL wrap_bitcnt got=%0d want=0", bus.o_BITCNT);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++)
         run_block($urandom_range(40, 1), $urandom_range(TO, 1),
                   1'($urandom_range(1)), 1'($urandom_range(1)),
                   $urandom_range(100, 30));
   endtask

   task automatic go_data(input int len_in, input int k);
      bus.i_PAGE_LEN = 10'(len_in);
      bus.i_ACQ_REQ = 1'b1;
      tick();
      bus.i_ACQ_REQ = 1'b0;
      m_crc = 1'b0;
      m_to = 1'b0;
      tick();
      for (int h = 1; h <= k; h++) begin
         bus.i_Z14_LOCKED_n = (h == k) ? 1'b0 : 1'b1;
         tick();
      end
      bus.i_Z14_LOCKED_n = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      go_data(40, 1);
      bus.i_BITSTB = 1'b1;
      repeat (5) tick();
      bus.i_BITSTB = 1'b0;
      total++;
      if (bus.o_BITCNT !== 10'd5)
         $display("FAIL abort_pre got=%0d want=5", bus.o_BITCNT);
      else passed++;
      bus.i_ABORT = 1'b1;
      bus.i_ACQ_REQ = 1'b1;
      tick();
      bus.i_ABORT = 1'b0;
      bus.i_ACQ_REQ = 1'b0;
      total++;
      if (ov() !== ev(0,1,0,0,0,0,0,1))
         $display("FAIL abort got=%b want=%b",
                  ov(), ev(0,1,0,0,0,0,0,1));
      else passed++;
      tick();
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,0))
         $display("FAIL abort_idle got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,0,0));
      else passed++;
      bus.i_ABORT = 1'b1;
      tick();
      bus.i_ABORT = 1'b0;
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,0))
         $display("FAIL abort_in_idle got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,0,0));
      else passed++;
      bus.i_ACQ_REQ = 1'b1;
      tick();
      bus.i_ACQ_REQ = 1'b0;
      m_to = 1'b0;
      tick();
      for (int h = 1; h <= TO; h++) begin
         bus.i_ABORT = (h == TO);
         tick();
      end
      bus.i_ABORT = 1'b0;
      total++;
      if (ov() !== ev(0,1,0,0,0,0,0,1))
         $display("FAIL abort_vs_timeout got=%b want=%b",
                  ov(), ev(0,1,0,0,0,0,0,1));
      else passed++;
   endtask

   task automatic test_cen_hold();
      go_data(20, 2);
      bus.i_BITSTB = 1'b1;
      repeat (2) tick();
      bus.i_CLK2M_PCEN_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (ov() !== ev(0,0,0,0,1,0,1,0) || bus.o_BITCNT !== 10'd2)
            $display("FAIL cen_hold got=%b/%0d want=%b/2",
                     ov(), bus.o_BITCNT, ev(0,0,0,0,1,0,1,0));
         else passed++;
      end
      bus.i_BITSTB = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m_crc = 1'b0;
      m_to = 1'b0;
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,0) || bus.o_BITCNT !== 10'd0)
         $display("FAIL async_reset got=%b/%0d want=%b/0",
                  ov(), bus.o_BITCNT, ev(0,0,0,0,0,0,0,0));
      else passed++;
      repeat (2) tick();
      rst_n = 1'b1;
      bus.i_CLK2M_PCEN_n = 1'b0;
      tick();
      total++;
      if (ov() !== ev(0,0,0,0,0,0,0,0))
         $display("FAIL post_reset got=%b want=%b",
                  ov(), ev(0,0,0,0,0,0,0,0));
      else passed++;
   endtask

   initial begin
      bus.i_CLK2M_PCEN_n = 1'b0;
      bus.i_BITSTB = 1'b0;
      bus.i_ACQ_REQ = 1'b0;
      bus.i_ABORT = 1'b0;
      bus.i_PAGE_LEN = '0;
      bus.i_Z14_LOCKED_n = 1'b1;
      bus.i_Z14_n = 1'b1;
      test_reset();
      test_crc_pass();
      test_back_to_back();
      test_timeout();
      test_lock_timeout_tie();
      test_wrap();
      test_random();
      test_abort();
      test_cen_hold();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/mdl_z14seq.md
# mdl_z14seq

Acquisition sequencer for the Z14 (CRC14) evaluator. For each block acquisition it produces the control strobes the evaluator consumes: acquisition start, data-length-counter start, supplementary-bubble active/end, and the per-bit shift enable. It also runs the 25K lock-hunt timer and samples the Z14 zero flag to report CRC pass/fail. It sits between the bubble page controller, which issues requests, and the Z14 evaluator.

## Interface
- TIMEOUT_CYC, 25000: lock-hunt limit in CEN cycles; 15-bit counter, legal range 1..32767.
- i_MCLK  in  1  master clock.
- i_SYS_RST_n  in  1  reset, asynchronous, active-low.
- i_CLK2M_PCEN_n  in  1  clock enable, active-low; all state advances only when low.
- i_BITSTB  in  1  bit-cell strobe, one CEN cycle per bubble bit.
- i_ACQ_REQ  in  1  acquisition request, level sampled.
- i_ABORT  in  1  abort request.
- i_PAGE_LEN  in  10  data+CRC bit count; 0 means 1024. Latched on accept.
- i_Z14_LOCKED_n  in  1  evaluator lock flag, active-low.
- i_Z14_n  in  1  evaluator zero flag; low = CRC residue zero.
- o_ACQ_START  out  1  high for the single ARM cycle.
- o_Z14_ERR_n  out  1  low for the ARM cycle and on abort/timeout; clears the evaluator lock.
- o_TIMER25K_TIMEOVER_n  out  1  low for one cycle on hunt timeout.
- o_DLCNT_START_n  out  1  low for the single START cycle.
- o_SUPBD_ACT_n  out  1  low throughout DATA.
- o_SUPBDLCNTR_CNT  out  1  i_BITSTB gated by DATA (combinational).
- o_SUPBD_END_n  out  1  low for the single END cycle.
- o_BITCNT  out  10  bits counted in the current block.
- o_BUSY  out  1  high whenever the state is not IDLE.
- o_DONE  out  1  one-cycle pulse at block completion.
- o_CRC_OK  out  1  result of the last completed block; held until the next accept.
- o_TIMEOUT  out  1  sticky flag, set by a timeout, cleared on accept.

## Operation
- Reset values: state IDLE, counters 0, o_CRC_OK=0, o_TIMEOUT=0. All active-low outputs are 1; all other outputs are 0.
- States: IDLE, ARM, HUNT, START, DATA, END, CHECK.
- IDLE: when i_ACQ_REQ=1, latch i_PAGE_LEN, clear o_CRC_OK, o_TIMEOUT, the timer and o_BITCNT, then go to ARM. Requests are ignored in every other state.
- ARM (1 cycle): assert o_ACQ_START and o_Z14_ERR_n=0, then go to HUNT.
- HUNT: the timer increments each cycle.
  - If i_Z14_LOCKED_n=0, go to START.
  - Otherwise, when timer==TIMEOUT_CYC-1, pulse o_TIMER25K_TIMEOVER_n and o_Z14_ERR_n, set o_TIMEOUT, pulse o_DONE, and return to IDLE.
  - If lock and timeout occur in the same cycle, lock wins.
- START (1 cycle): assert o_DLCNT_START_n=0. An i_BITSTB in this cycle is not counted. Go to DATA.
- DATA: each i_BITSTB increments o_BITCNT (10-bit, wraps). On the strobe where o_BITCNT==latched_len-1 (mod 1024), go to END. That final strobe is counted and forwarded on o_SUPBDLCNTR_CNT.
- END (1 cycle): assert o_SUPBD_END_n=0. Go to CHECK.
- CHECK (1 cycle): set o_CRC_OK=~i_Z14_n, pulse o_DONE, go to IDLE.
- i_ABORT=1 in any non-IDLE state:
  - pulses o_Z14_ERR_n and o_DONE;
  - leaves o_CRC_OK=0 and o_TIMEOUT unchanged;
  - returns to IDLE next cycle.
  - Abort has priority over every other transition, including timeout.
  - In IDLE, i_ABORT has no effect.
- Reset asserted mid-operation returns everything to the reset values immediately, with no pulses.

## Timing
- Unit is one CEN cycle (i_CLK2M_PCEN_n low at a rising i_MCLK edge). With the enable held high, all state holds.
- Accept to o_ACQ_START: 1 cycle. When lock is already asserted on the first HUNT cycle, o_DLCNT_START_n falls 2 cycles after o_ACQ_START.
- Last counted strobe → o_SUPBD_END_n low on the next cycle → o_DONE/o_CRC_OK on the cycle after that.
- Minimum length for a 1-bit block with an immediate lock: 7 cycles from accept to o_DONE, plus the strobe wait.
- Timeout: o_TIMER25K_TIMEOVER_n falls on the TIMEOUT_CYC-th HUNT cycle.
- All pulse outputs are exactly one CEN cycle wide and registered, except o_SUPBDLCNTR_CNT, which is combinational.

## Test plan
- PAGE_LEN=16, lock on the 3rd HUNT cycle, 16 strobes, i_Z14_n=0 at CHECK -> o_SUPBDLCNTR_CNT pulses 16 times; o_BITCNT=16; END, then o_DONE; o_CRC_OK=1.
- Same block with i_Z14_n=1 -> o_CRC_OK=0; a second request is accepted the cycle after o_DONE.
- TIMEOUT_CYC=8, lock never asserted -> o_TIMER25K_TIMEOVER_n low on the 8th HUNT cycle; o_TIMEOUT=1; o_DONE; no o_DLCNT_START_n pulse.
- PAGE_LEN=0 -> exactly 1024 strobes counted before END; o_BITCNT wraps to 0.
- i_ABORT after 5 DATA strobes, issued together with an i_ACQ_REQ -> o_Z14_ERR_n and o_DONE pulse, IDLE next cycle, and the request is ignored. Separately, lock and timeout in the same cycle -> START is entered.
- Reset asserted during DATA and CEN held high for 3 cycles -> outputs return to reset values asynchronously; no state change while the enable is inactive.
